// File: rtl/mem_access_pkg.sv
// Shared types for the memory stage and the data-cache bus.
// Access size encoding and dbus request/response bundles.
package mem_access_pkg;

  typedef enum logic [1:0] {
    MSIZE1,
    MSIZE2,
    MSIZE4,
    MSIZE8
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/mem_access_unit.sv
// Memory-stage load/store adapter in front of the data cache.
// One op in flight; registered dbus request, extended load result.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_store,
  input  msize_t      in_size,
  input  logic        in_signed,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rdata,
  output logic        out_misaligned,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t      state_q;
  dbus_req_t   req_q;
  logic        store_q;
  logic        sgn_q;
  logic        mis_q;
  logic [63:0] rdata_q;

  logic        misal;
  logic [7:0]  strb_base;
  logic [7:0]  strb_sh;
  logic [63:0] wdata_sh;
  logic [63:0] ld_sh;
  logic [63:0] ld_ext;

  always_comb begin
    misal     = 1'b0;
    strb_base = 8'h01;
    unique case (in_size)
      MSIZE1: begin
        misal     = 1'b0;
        strb_base = 8'h01;
      end
      MSIZE2: begin
        misal     = in_addr[0];
        strb_base = 8'h03;
      end
      MSIZE4: begin
        misal     = |in_addr[1:0];
        strb_base = 8'h0F;
      end
      MSIZE8: begin
        misal     = |in_addr[2:0];
        strb_base = 8'hFF;
      end
    endcase
  end

  assign strb_sh  = strb_base << in_addr[2:0];
  assign wdata_sh = in_wdata << {in_addr[2:0], 3'b000};
  assign ld_sh    = dresp.data >> {req_q.addr[2:0], 3'b000};

  always_comb begin
    ld_ext = ld_sh;
    unique case (req_q.size)
      MSIZE1: ld_ext = {{56{sgn_q & ld_sh[7]}}, ld_sh[7:0]};
      MSIZE2: ld_ext = {{48{sgn_q & ld_sh[15]}}, ld_sh[15:0]};
      MSIZE4: ld_ext = {{32{sgn_q & ld_sh[31]}}, ld_sh[31:0]};
      MSIZE8: ld_ext = ld_sh;
    endcase
  end

  // dreq is held verbatim from accept until the data_ok edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      store_q <= 1'b0;
      sgn_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            store_q      <= in_is_store;
            sgn_q        <= in_signed;
            req_q.addr   <= in_addr;
            req_q.size   <= in_size;
            req_q.strobe <= in_is_store ? strb_sh : 8'h00;
            req_q.data   <= wdata_sh;
            if (CHECK_ALIGN && misal) begin
              mis_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= DONE;
            end else begin
              req_q.valid <= 1'b1;
              state_q     <= REQ;
            end
          end
        end
        REQ: begin
          if (dresp.addr_ok && dresp.data_ok) begin
            rdata_q     <= store_q ? 64'd0 : ld_ext;
            req_q.valid <= 1'b0;
            state_q     <= DONE;
          end else if (dresp.addr_ok) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (dresp.data_ok) begin
            rdata_q     <= store_q ? 64'd0 : ld_ext;
            req_q.valid <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            mis_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign out_valid      = (state_q == DONE);
  assign out_rdata      = rdata_q;
  assign out_misaligned = mis_q;
  assign dreq           = req_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store adapter that sits directly upstream of the data cache. It accepts one memory operation from the pipeline and generates the byte strobe and lane-shifted store data. It drives a `dbus_req_t` to the cache and holds it stable until `data_ok`. For loads, it extracts and sign- or zero-extends the returned lane. Only one operation is in flight at a time, so the pipeline sees a simple valid/ready handshake on both sides.

## Interface
- `CHECK_ALIGN`, default 1: when 1, a misaligned access is trapped and never reaches the bus. When 0, alignment is not checked and the access is issued as-is.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset; the block is in reset while `reset`==0.
- `in_valid` in 1: the pipeline presents an operation.
- `in_ready` out 1: the block can accept an operation.
- `in_is_store` in 1: 1=store, 0=load.
- `in_size` in `msize_t`: MSIZE1/2/4/8.
- `in_signed` in 1: sign-extend the load result; ignored for stores.
- `in_addr` in 64: byte address.
- `in_wdata` in 64: store data, right-aligned (LSB-justified).
- `out_valid` out 1: result available.
- `out_ready` in 1: the pipeline consumes the result.
- `out_rdata` out 64: extended load data; 0 for stores.
- `out_misaligned` out 1: the operation was trapped as misaligned.
- `dreq` out `dbus_req_t`: request to the data cache.
- `dresp` in `dbus_resp_t`: response from the data cache.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, latch op, size, signed, addr and wdata.
  - If `CHECK_ALIGN` and the address is misaligned, set `out_misaligned`=1 and `out_rdata`=0, then go to DONE.
  - Otherwise go to REQ.
  - Misaligned means `addr[0]`≠0 for size 2, `addr[1:0]`≠0 for size 4, `addr[2:0]`≠0 for size 8.
- **REQ**
  - `dreq.valid`=1.
  - `addr_ok` & `data_ok` in the same cycle → capture data, go to DONE.
  - `addr_ok` only → go to WAIT.
  - Otherwise stay in REQ.
- **WAIT**
  - `dreq.valid` stays 1 with all fields unchanged, because the cache reads `dreq` directly during refill.
  - `data_ok` → capture data, go to DONE.
- **DONE**
  - `out_valid`=1 and `dreq.valid`=0.
  - `out_ready` → go to IDLE, clear `out_misaligned`.
- **Request field generation** (let `o`=`addr[2:0]`):
  - `dreq.addr`=`in_addr`, `dreq.size`=`in_size`.
  - Store strobe is 8'h01, 8'h03, 8'h0F or 8'hFF according to size, shifted left by `o`, truncated to 8 bits.
  - Load strobe is 0.
  - `dreq.data` = wdata << (8·`o`), truncated to 64 bits.
- **Load data**
  - Shift `r` = `dresp.data` >> (8·`o`).
  - Take the low 8/16/32/64 bits of `r`.
  - Extend from the top bit if `in_signed`, otherwise zero-extend.
  - Register the result into `out_rdata` on the `data_ok` cycle.
- **Store result**: `out_rdata`=0.
- **Reset** (`reset`==0, at any time, including during REQ or WAIT):
  - State → IDLE.
  - `dreq.valid`, `out_valid` and `out_misaligned` → 0.
  - `out_rdata` → 0 and all latched request fields → 0.
  - `in_ready` becomes 1 once reset is released.
  - A pending cache transaction is abandoned; the cache is reset by the same signal.

## Timing
- `dreq` and the `out_*` outputs are driven only from registers or the current state. No combinational path from `dresp` to `dreq`.
- `in_ready` = (state==IDLE). There is no combinational dependence on `in_valid`.
- **Accept in cycle N:**
  - `dreq.valid` goes high at N+1.
  - On a cache hit (`addr_ok` and `data_ok` at N+1), `out_valid` goes high at N+2.
- **Miss:** `out_valid` is asserted the cycle after the `data_ok` cycle.
- **Misaligned op:** `out_valid` goes high at N+1 and `dreq.valid` never rises.
- **Release of `dreq.valid`:** it falls in the cycle after `data_ok`, so the cache never sees a duplicate request.
- **Throughput:** at most one op per 3 cycles (IDLE→REQ→DONE).
- **Back-pressure:** while `out_valid`=1 and `out_ready`=0, `out_rdata` and `out_misaligned` hold their values.
- A `data_ok` that arrives while the block is in IDLE or DONE is ignored.

## Test plan
- Aligned load hit: load of size 8 at `addr`=0x8000_0010, cache answers `addr_ok`+`data_ok` with data 0x1122334455667788 in the same cycle → `out_valid` two cycles after accept, `out_rdata`=0x1122334455667788, strobe 0.
- Signed byte load: MSIZE1, `addr`=0x8000_0005, signed=1, `dresp.data`=0x0000_8000_0000_0000 (0x80 in byte lane 5) → `out_rdata`=0xFFFF_FFFF_FFFF_FF80. The same stimulus with signed=0 → `out_rdata`=0x80.
- Halfword store: MSIZE2, `addr`=0x8000_0006, wdata=0xBEEF → `dreq.strobe`=8'hC0, `dreq.data`=0xBEEF_0000_0000_0000, `out_rdata`=0.
- Miss: `addr_ok` at N+1, `data_ok` at N+20 → `dreq` stays valid with all fields constant from N+1 through N+20, `dreq.valid`=0 at N+21, `out_valid` at N+21.
- Misaligned: MSIZE4 at `addr`=0x8000_0002 → `dreq.valid` never rises, `out_valid` at N+1, `out_misaligned`=1. A following aligned op shows `out_misaligned`=0.
- Reset during WAIT, plus back-pressure:
  - Drive `reset`=0 asynchronously mid-cycle → `dreq.valid` and `out_valid` drop without waiting for a clock edge.
  - After release, `in_ready`=1.
  - Hold `out_ready`=0 for 5 cycles → `out_rdata` stays stable and no new `dreq` is issued.
